// File: rtl/spi_pkg.sv
// Shared constants and helpers for the SPI slave: bit-order encoding,
// default geometry and the shift direction implied by a bit order.
package spi_pkg;

  localparam int SPI_MSB_FIRST = 0;
  localparam int SPI_LSB_FIRST = 1;

  localparam int SPI_DEF_WIDTH = 8;
  localparam int SPI_DEF_CNT_W = 8;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  // MSB-first moves data toward bit WIDTH-1; LSB-first toward bit 0.
  function automatic shift_dir_e spi_shift_dir(input int lsb_first);
    return (lsb_first == SPI_LSB_FIRST) ? SHIFT_RIGHT : SHIFT_LEFT;
  endfunction

endpackage

// File: rtl/spi_slave_word_if.sv
// Pin-side bundle of the word-oriented SPI slave: serial lines, chip select
// and the parallel word/strobe side toward the sclk-domain consumer.
interface spi_slave_word_if
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_DEF_WIDTH,
  parameter int CNT_W = SPI_DEF_CNT_W
);

  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             frame_err;
  logic [CNT_W-1:0] rx_count;

  modport slave (
    input  cs_n, mosi, tx_data,
    output miso, tx_load, rx_data, rx_valid, frame_err, rx_count
  );

  modport master (
    output cs_n, mosi, tx_data,
    input  miso, tx_load, rx_data, rx_valid, frame_err, rx_count
  );

endinterface

// File: rtl/spi_shift_reg.sv
// WIDTH-bit shift register with async reset, parallel load (priority over
// shift), serial input and a serial-out tap at the end data shifts toward.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int         WIDTH = SPI_DEF_WIDTH,
  parameter shift_dir_e DIR   = SHIFT_LEFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] shifted,
  output logic             serial_out
);

  // shifted is the value after one more shift; the receiver captures it
  // directly on the last bit edge so the word includes that edge's bit.
  assign shifted    = (DIR == SHIFT_LEFT) ? {q[WIDTH-2:0], serial_in}
                                          : {serial_in, q[WIDTH-1:1]};
  assign serial_out = (DIR == SHIFT_LEFT) ? q[WIDTH-1] : q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/spi_slave_word.sv
// Full-duplex SPI slave clocked by sclk: framing on cs_n, bit counter,
// rx/tx shift registers, one-cycle strobes and a wrapping word counter.
module spi_slave_word
  import spi_pkg::*;
#(
  parameter int WIDTH     = SPI_DEF_WIDTH,
  parameter int LSB_FIRST = SPI_MSB_FIRST,
  parameter int CNT_W     = SPI_DEF_CNT_W
) (
  input  logic                sclk,
  input  logic                rst,
  spi_slave_word_if.slave     bus
);

  localparam int               BC_W     = $clog2(WIDTH);
  localparam shift_dir_e       DIR      = spi_shift_dir(LSB_FIRST);
  localparam logic [BC_W-1:0]  LAST_IDX = BC_W'(WIDTH - 1);

  logic [BC_W-1:0]  bit_cnt;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_load;
  logic             frame_err;
  logic [CNT_W-1:0] rx_count;

  logic             selected;
  logic             last_bit;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] rx_next;
  logic             rx_unused;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] tx_shifted;
  logic             tx_unused;

  assign selected = !bus.cs_n;
  assign last_bit = selected && (bit_cnt == LAST_IDX);

  // Deselect clears any partial word so a new frame starts from zero.
  spi_shift_reg #(
    .WIDTH (WIDTH),
    .DIR   (DIR)
  ) u_rx (
    .clk        (sclk),
    .rst        (rst),
    .load       (bus.cs_n),
    .load_data  ('0),
    .shift      (selected),
    .serial_in  (bus.mosi),
    .q          (rx_q),
    .shifted    (rx_next),
    .serial_out (rx_unused)
  );

  // Reload on the idle edge and on each word's last edge so back-to-back
  // words stream without gap cycles.
  spi_shift_reg #(
    .WIDTH (WIDTH),
    .DIR   (DIR)
  ) u_tx (
    .clk        (sclk),
    .rst        (rst),
    .load       (bus.cs_n || last_bit),
    .load_data  (bus.tx_data),
    .shift      (selected),
    .serial_in  (1'b0),
    .q          (tx_q),
    .shifted    (tx_shifted),
    .serial_out (bus.miso)
  );

  assign tx_unused = ^{tx_q, tx_shifted, rx_q, rx_unused};

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      frame_err <= 1'b0;
      rx_count  <= '0;
    end else begin
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      frame_err <= 1'b0;
      if (bus.cs_n) begin
        bit_cnt   <= '0;
        tx_load   <= 1'b1;
        frame_err <= (bit_cnt != '0);
      end else if (last_bit) begin
        bit_cnt  <= '0;
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
        rx_count <= rx_count + 1'b1;
        tx_load  <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.tx_load   = tx_load;
  assign bus.frame_err = frame_err;
  assign bus.rx_count  = rx_count;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: an MSB-first/CNT_W=8 and an LSB-first/CNT_W=2
// instance share one serial stimulus and are scored against a word model.
module tb_spi_slave_word;

  logic       sclk = 1'b0;
  logic       rst  = 1'b1;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;

  spi_slave_word_if #(.WIDTH(8), .CNT_W(8)) b0 ();
  spi_slave_word_if #(.WIDTH(8), .CNT_W(2)) b1 ();

  assign b0.cs_n = cs_n;  assign b0.mosi = mosi;  assign b0.tx_data = tx_data;
  assign b1.cs_n = cs_n;  assign b1.mosi = mosi;  assign b1.tx_data = tx_data;

  spi_slave_word #(.WIDTH(8), .LSB_FIRST(0), .CNT_W(8)) dut0 (
    .sclk(sclk), .rst(rst), .bus(b0.slave));
  spi_slave_word #(.WIDTH(8), .LSB_FIRST(1), .CNT_W(2)) dut1 (
    .sclk(sclk), .rst(rst), .bus(b1.slave));

  always #5 sclk = ~sclk;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         ferr0, ferr1;
  int         cnt0, cnt1;
  logic [7:0] last0, last1;
  int         lastc0, lastc1;
  bit         pending;
  int         n_checks, n_fail;

  logic [7:0] rxw[$];
  int         tx_first;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Bit k of a word as it appears on the wire for the given order.
  function automatic logic wire_bit(input logic [7:0] t, input int k, input bit lsb);
    return lsb ? t[k] : t[7-k];
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic reset_model();
    q0.delete(); q1.delete();
    ferr0 = 0; ferr1 = 0; cnt0 = 0; cnt1 = 0;
    last0 = 8'h00; last1 = 8'h00; lastc0 = 0; lastc1 = 0;
    pending = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rx_data0",  b0.rx_data,   0); chk("rst_rx_data1",  b1.rx_data,   0);
    chk("rst_rx_count0", b0.rx_count,  0); chk("rst_rx_count1", b1.rx_count,  0);
    chk("rst_rx_valid0", b0.rx_valid,  0); chk("rst_rx_valid1", b1.rx_valid,  0);
    chk("rst_tx_load0",  b0.tx_load,   0); chk("rst_tx_load1",  b1.tx_load,   0);
    chk("rst_ferr0",     b0.frame_err, 0); chk("rst_ferr1",     b1.frame_err, 0);
    chk("rst_miso0",     b0.miso,      0); chk("rst_miso1",     b1.miso,      0);
  endtask

  task automatic edge_(input logic cs, input logic b);
    @(negedge sclk);
    cs_n = cs;
    mosi = b;
    @(posedge sclk);
    #1;
  endtask

  task automatic idle_edge();
    edge_(1'b1, 1'($urandom_range(0, 1)));
    if (pending) begin
      ferr0++; ferr1++;
      pending = 0;
    end
  endtask

  // One frame: idle edge, every word in rxw, then 'partial' extra bits.
  task automatic run_frame(input int partial);
    logic [7:0] tw[$];
    logic [7:0] w;
    int         n;
    n = rxw.size();
    for (int i = 0; i <= n; i++) tw.push_back(8'($urandom_range(0, 255)));
    if (tx_first >= 0) tw[0] = 8'(tx_first);
    tx_data = tw[0];
    idle_edge();
    chk("tx_load_idle0", b0.tx_load, 1); chk("tx_load_idle1", b1.tx_load, 1);
    tx_data = tw[imin(1, n)];
    chk("miso0", b0.miso, wire_bit(tw[0], 0, 0));
    chk("miso1", b1.miso, wire_bit(tw[0], 0, 1));
    for (int wi = 0; wi < n; wi++) begin
      w = rxw[wi];
      for (int k = 0; k < 8; k++) begin
        edge_(1'b0, w[7-k]);
        if (k == 7) begin
          cnt0 = (cnt0 + 1) % 256;
          cnt1 = (cnt1 + 1) % 4;
          q0.push_back('{d: w,       c: cnt0});
          q1.push_back('{d: rev8(w), c: cnt1});
          chk("tx_load_last0", b0.tx_load, 1); chk("tx_load_last1", b1.tx_load, 1);
          tx_data = tw[imin(wi + 2, n)];
          chk("miso0", b0.miso, wire_bit(tw[wi+1], 0, 0));
          chk("miso1", b1.miso, wire_bit(tw[wi+1], 0, 1));
        end else begin
          chk("tx_load_mid0", b0.tx_load, 0); chk("tx_load_mid1", b1.tx_load, 0);
          chk("miso0", b0.miso, wire_bit(tw[wi], k + 1, 0));
          chk("miso1", b1.miso, wire_bit(tw[wi], k + 1, 1));
        end
      end
    end
    for (int k = 0; k < partial; k++) begin
      edge_(1'b0, 1'($urandom_range(0, 1)));
      chk("tx_load_part0", b0.tx_load, 0); chk("tx_load_part1", b1.tx_load, 0);
      chk("miso0", b0.miso, wire_bit(tw[n], k + 1, 0));
      chk("miso1", b1.miso, wire_bit(tw[n], k + 1, 1));
    end
    if (partial > 0) pending = 1;
    tx_first = -1;
    rxw.delete();
  endtask

  // Scoreboard monitor: pops an expectation for every strobe the DUTs raise.
  always @(negedge sclk) begin
    exp_t e;
    if (!rst) begin
      if (b0.rx_valid) begin
        chk("rx_valid0_expected", (q0.size() > 0), 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("rx_data0", b0.rx_data, e.d);
          chk("rx_count0", b0.rx_count, e.c);
          last0 = e.d; lastc0 = e.c;
        end
      end else begin
        chk("rx_data0_hold", b0.rx_data, last0);
        chk("rx_count0_hold", b0.rx_count, lastc0);
      end
      if (b1.rx_valid) begin
        chk("rx_valid1_expected", (q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("rx_data1", b1.rx_data, e.d);
          chk("rx_count1", b1.rx_count, e.c);
          last1 = e.d; lastc1 = e.c;
        end
      end else begin
        chk("rx_data1_hold", b1.rx_data, last1);
        chk("rx_count1_hold", b1.rx_count, lastc1);
      end
      if (b0.frame_err) begin
        chk("frame_err0_expected", (ferr0 > 0), 1);
        if (ferr0 > 0) ferr0--;
      end
      if (b1.frame_err) begin
        chk("frame_err1_expected", (ferr1 > 0), 1);
        if (ferr1 > 0) ferr1--;
      end
    end
  end

  initial begin
    int nw;
    int part;
    n_checks = 0; n_fail = 0;
    tx_first = -1;
    reset_model();
    #2;
    chk_reset_outputs();
    @(negedge sclk);
    rst = 1'b0;

    // Asynchronous reset in the middle of a word, with miso driven high.
    tx_data = 8'hFF;
    idle_edge();
    chk("miso_before_rst0", b0.miso, 1);
    for (int k = 0; k < 3; k++) edge_(1'b0, 1'b1);
    #2;
    rst  = 1'b1;
    cs_n = 1'b1;
    #1;
    chk_reset_outputs();
    reset_model();
    @(negedge sclk);
    rst = 1'b0;
    rxw.push_back(8'h5A);
    run_frame(0);

    rxw.push_back(8'hA5);
    run_frame(0);
    rxw.push_back(8'h80);
    run_frame(0);
    tx_first = 8'hC3;
    rxw.push_back(8'h3C);
    run_frame(0);
    rxw.push_back(8'h12);
    rxw.push_back(8'h34);
    run_frame(0);
    // Frame abandoned after 5 bits, then a clean word.
    run_frame(5);
    rxw.push_back(8'hE7);
    run_frame(0);

    for (int f = 0; f < 25; f++) begin
      nw = $urandom_range(0, 3);
      for (int i = 0; i < nw; i++) rxw.push_back(8'($urandom_range(0, 255)));
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(part);
      if ($urandom_range(0, 2) == 0) idle_edge();
    end

    idle_edge();
    idle_edge();
    @(negedge sclk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("ferr0_drained", ferr0, 0);
    chk("ferr1_drained", ferr1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
